// File: rtl/example_pack.sv
// example_pack: pairs consecutive PAR0-wide input words into one PAR1-wide
// word (first word in the low half) and buffers the packed words in a
// DEPTH-entry FIFO. A flush closes a half-filled pair by zero-padding the
// high half. A flush that arrives with an input word and no half-word held
// pushes that word alone, zero-padded.
//
// Optional feature: define EXAMPLE_PACK_PARITY_EN to add out_par, the even
// parity of out_bus1. It is computed at push time and stored per entry.
//
// Ports:
//   example_clk    clock, all state on rising edge
//   example_rst_n  asynchronous active-low reset
//   in_vld/in_rdy  input handshake, in_bus0 is the input word
//   in_flush       close the current pair, zero-padded (level)
//   out_vld/out_rdy output handshake, out_bus1 is the FIFO head data
//   out_pad        head entry had its high half zero-padded
//   out_cnt        FIFO occupancy
//   out_par        (EXAMPLE_PACK_PARITY_EN only) parity of out_bus1
//
// Pack FSM states:
//   state   | meaning
//   ST_LOW  | no half-word held
//   ST_HALF | low half held in hold_q
module example_pack #(
  parameter int PAR0  = 16,
  parameter int PAR1  = 32,
  parameter int DEPTH = 4
) (
  input  logic                         example_clk,
  input  logic                         example_rst_n,
  input  logic                         in_vld,
  output logic                         in_rdy,
  input  logic [PAR0-1:0]              in_bus0,
  input  logic                         in_flush,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output logic [PAR1-1:0]              out_bus1,
  output logic                         out_pad,
  output logic [$clog2(DEPTH+1)-1:0]   out_cnt
`ifdef EXAMPLE_PACK_PARITY_EN
  ,
  output logic                         out_par
`endif
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
`ifdef EXAMPLE_PACK_PARITY_EN
  localparam int EW = PAR1 + 2;  // {parity, pad, data}
`else
  localparam int EW = PAR1 + 1;  // {pad, data}
`endif

  if (PAR1 != 2*PAR0) begin : g_bad_par1
    $error("example_pack: PAR1 must equal 2*PAR0");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH-1)) != 0)) begin : g_bad_depth
    $error("example_pack: DEPTH must be a power of two, at least 2");
  end

  typedef enum logic {
    ST_LOW  = 1'b0,
    ST_HALF = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [PAR0-1:0]   hold_q, hold_d;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     cnt_q;
  logic [EW-1:0]     mem_q [DEPTH];

  logic              pop, space, accept;
  logic              push, push_pad;
  logic [PAR1-1:0]   push_data;
  logic [EW-1:0]     push_entry;
  logic [EW-1:0]     head;

  // A same-cycle pop frees an entry, so in_rdy depends combinationally on out_rdy.
  assign pop    = out_vld && out_rdy;
  assign space  = (cnt_q != CW'(DEPTH)) || pop;
  assign in_rdy = ((state_q == ST_LOW) && !in_flush) ? 1'b1 : space;
  assign accept = in_vld && in_rdy;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    push      = 1'b0;
    push_pad  = 1'b0;
    push_data = '0;
    case (state_q)
      ST_LOW: begin
        if (accept) begin
          if (in_flush) begin
            push      = 1'b1;
            push_pad  = 1'b1;
            push_data = {{PAR0{1'b0}}, in_bus0};
          end else begin
            hold_d  = in_bus0;
            state_d = ST_HALF;
          end
        end
      end
      ST_HALF: begin
        if (accept) begin
          // completing the pair takes priority over a concurrent flush
          push      = 1'b1;
          push_data = {in_bus0, hold_q};
          state_d   = ST_LOW;
        end else if (in_flush && space) begin
          push      = 1'b1;
          push_pad  = 1'b1;
          push_data = {{PAR0{1'b0}}, hold_q};
          state_d   = ST_LOW;
        end
      end
      default: state_d = ST_LOW;
    endcase
  end

`ifdef EXAMPLE_PACK_PARITY_EN
  assign push_entry = {^push_data, push_pad, push_data};
`else
  assign push_entry = {push_pad, push_data};
`endif

  always_ff @(posedge example_clk or negedge example_rst_n) begin
    if (!example_rst_n) begin
      state_q  <= ST_LOW;
      hold_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      if (push) begin
        mem_q[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head     = mem_q[rd_ptr_q];
  assign out_vld  = (cnt_q != '0);
  assign out_cnt  = cnt_q;
  assign out_bus1 = head[PAR1-1:0];
  assign out_pad  = head[PAR1];
`ifdef EXAMPLE_PACK_PARITY_EN
  assign out_par  = head[PAR1+1];
`endif

endmodule

// File: tb/tb_example_pack.sv
// Testbench for example_pack: directed scenarios plus a randomized run
// against a queue-based reference model of the packer and FIFO.
module tb_example_pack;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_vld, in_rdy, in_flush;
  logic [15:0] in_bus0;
  logic        out_vld, out_rdy, out_pad;
  logic [31:0] out_bus1;
  logic [2:0]  out_cnt;
`ifdef EXAMPLE_PACK_PARITY_EN
  logic        out_par;
`endif

  always #5 clk = ~clk;

  example_pack #(.PAR0(16), .PAR1(32), .DEPTH(D)) dut (
    .example_clk   (clk),
    .example_rst_n (rst_n),
    .in_vld        (in_vld),
    .in_rdy        (in_rdy),
    .in_bus0       (in_bus0),
    .in_flush      (in_flush),
    .out_vld       (out_vld),
    .out_rdy       (out_rdy),
    .out_bus1      (out_bus1),
    .out_pad       (out_pad),
    .out_cnt       (out_cnt)
`ifdef EXAMPLE_PACK_PARITY_EN
    ,
    .out_par       (out_par)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: queue of {pad, data} entries plus an optional held half-word.
  logic [32:0] mq[$];
  bit          m_half;
  logic [15:0] m_hold;
  bit          e_rdy, e_acc, e_space;

  task automatic model_clear();
    mq.delete();
    m_half = 0;
    m_hold = '0;
  endtask

  // Apply inputs for this cycle and derive what the model expects of it.
  task automatic drive(input bit v, input logic [15:0] b, input bit f, input bit r);
    bit pop;
    in_vld = v; in_bus0 = b; in_flush = f; out_rdy = r;
    #1;
    pop     = (mq.size() > 0) && r;
    e_space = (mq.size() < D) || pop;
    e_rdy   = (!m_half && !f) ? 1'b1 : e_space;
    e_acc   = v && e_rdy;
  endtask

  // Advance one clock and update the model with what that edge did.
  task automatic tick();
    bit          pop, push;
    logic [32:0] ent;
    pop  = (mq.size() > 0) && out_rdy;
    push = 0;
    ent  = '0;
    @(posedge clk);
    #1;
    if (e_acc && !m_half && !in_flush) begin
      m_half = 1; m_hold = in_bus0;
    end else if (e_acc && !m_half) begin
      push = 1; ent = {1'b1, 16'h0000, in_bus0};
    end else if (e_acc) begin
      push = 1; ent = {1'b0, in_bus0, m_hold}; m_half = 0;
    end else if (m_half && in_flush && e_space) begin
      push = 1; ent = {1'b1, 16'h0000, m_hold}; m_half = 0;
    end
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(ent);
  endtask

  task automatic test_reset();
    in_vld = 0; in_bus0 = '0; in_flush = 0; out_rdy = 0;
    rst_n = 0;
    model_clear();
    #12;
    rst_n = 1;
    @(posedge clk); #1;
    n_cmp++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL reset_out_vld got %b want 0", out_vld); end
    n_cmp++; if (out_cnt !== 3'd0) begin n_err++; $display("FAIL reset_out_cnt got %0d want 0", out_cnt); end
    n_cmp++; if (out_pad !== 1'b0) begin n_err++; $display("FAIL reset_out_pad got %b want 0", out_pad); end
    n_cmp++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL reset_in_rdy got %b want 1", in_rdy); end
  endtask

  task automatic test_pair();
    drive(1, 16'h1234, 0, 1);
    n_cmp++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL pair_rdy0 got %b want 1", in_rdy); end
    tick();
    drive(1, 16'hABCD, 0, 1);
    n_cmp++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL pair_no_bypass got %b want 0", out_vld); end
    tick();
    drive(0, 16'h0, 0, 1);
    n_cmp++; if (out_vld !== 1'b1) begin n_err++; $display("FAIL pair_vld got %b want 1", out_vld); end
    n_cmp++; if (out_bus1 !== 32'hABCD_1234) begin n_err++; $display("FAIL pair_data got %h want abcd1234", out_bus1); end
    n_cmp++; if (out_pad !== 1'b0) begin n_err++; $display("FAIL pair_pad got %b want 0", out_pad); end
    tick();
    drive(0, 16'h0, 0, 1);
    n_cmp++; if (out_cnt !== 3'd0) begin n_err++; $display("FAIL pair_cnt_after_pop got %0d want 0", out_cnt); end
    tick();
  endtask

  task automatic test_flush_half();
    drive(1, 16'h00FF, 0, 0); tick();
    drive(0, 16'h0, 1, 0);
    n_cmp++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL flush_half_rdy got %b want 1", in_rdy); end
    tick();
    drive(0, 16'h0, 0, 0);
    n_cmp++; if (out_cnt !== 3'd1) begin n_err++; $display("FAIL flush_half_cnt got %0d want 1", out_cnt); end
    n_cmp++; if (out_bus1 !== 32'h0000_00FF) begin n_err++; $display("FAIL flush_half_data got %h want 000000ff", out_bus1); end
    n_cmp++; if (out_pad !== 1'b1) begin n_err++; $display("FAIL flush_half_pad got %b want 1", out_pad); end
    tick();
    // back in LOW: another flush without a word must not push
    drive(0, 16'h0, 1, 1); tick();
    drive(0, 16'h0, 0, 0);
    n_cmp++; if (out_cnt !== 3'd0) begin n_err++; $display("FAIL flush_half_state got cnt %0d want 0", out_cnt); end
    tick();
  endtask

  task automatic test_flush_low();
    drive(1, 16'h5A5A, 1, 0);
    n_cmp++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL flush_low_rdy got %b want 1", in_rdy); end
    tick();
    drive(0, 16'h0, 0, 0);
    n_cmp++; if (out_cnt !== 3'd1) begin n_err++; $display("FAIL flush_low_cnt got %0d want 1", out_cnt); end
    n_cmp++; if (out_bus1 !== 32'h0000_5A5A) begin n_err++; $display("FAIL flush_low_data got %h want 00005a5a", out_bus1); end
    n_cmp++; if (out_pad !== 1'b1) begin n_err++; $display("FAIL flush_low_pad got %b want 1", out_pad); end
    tick();
    drive(0, 16'h0, 1, 1); tick();
    drive(0, 16'h0, 0, 0);
    n_cmp++; if (out_cnt !== 3'd0) begin n_err++; $display("FAIL flush_low_no_half got cnt %0d want 0", out_cnt); end
    tick();
  endtask

  task automatic test_full();
    logic [15:0] w [10];
    logic [31:0] exp;
    for (int i = 0; i < 10; i++) w[i] = 16'($urandom);
    for (int i = 0; i < 8; i++) begin
      drive(1, w[i], 0, 0);
      n_cmp++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL full_fill_rdy word %0d got %b want 1", i, in_rdy); end
      tick();
    end
    drive(1, w[8], 0, 0);
    n_cmp++; if (out_cnt !== 3'd4) begin n_err++; $display("FAIL full_cnt got %0d want 4", out_cnt); end
    n_cmp++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL full_ninth_rdy got %b want 1", in_rdy); end
    tick();
    drive(1, w[9], 0, 0);
    n_cmp++; if (in_rdy !== 1'b0) begin n_err++; $display("FAIL full_tenth_blocked got %b want 0", in_rdy); end
    tick();
    drive(1, w[9], 0, 1);
    n_cmp++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL full_pop_frees got %b want 1", in_rdy); end
    n_cmp++; if (out_bus1 !== {w[1], w[0]}) begin n_err++; $display("FAIL full_head0 got %h want %h", out_bus1, {w[1], w[0]}); end
    tick();
    drive(0, 16'h0, 0, 0);
    n_cmp++; if (out_cnt !== 3'd4) begin n_err++; $display("FAIL full_cnt_pushpop got %0d want 4", out_cnt); end
    for (int k = 1; k < 5; k++) begin
      drive(0, 16'h0, 0, 1);
      exp = {w[2*k+1], w[2*k]};
      n_cmp++; if (out_bus1 !== exp || out_pad !== 1'b0) begin n_err++; $display("FAIL full_drain%0d got %h/%b want %h/0", k, out_bus1, out_pad, exp); end
      tick();
    end
    drive(0, 16'h0, 0, 0);
    n_cmp++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL full_drained_vld got %b want 0", out_vld); end
  endtask

  task automatic test_random();
    bit          v, f, r;
    logic [15:0] b;
    logic [32:0] h;
    v = 0; b = '0;
    for (int c = 0; c < 400; c++) begin
      // a word refused last cycle stays stable upstream
      if (!(v && !e_acc)) begin
        v = ($urandom_range(0, 3) != 0);
        b = 16'($urandom);
      end
      f = ($urandom_range(0, 5) == 0);
      r = ($urandom_range(0, 2) != 0);
      drive(v, b, f, r);
      n_cmp++; if (in_rdy !== e_rdy) begin n_err++; $display("FAIL rand_rdy cyc %0d got %b want %b", c, in_rdy, e_rdy); end
      n_cmp++; if (out_cnt !== 3'(mq.size())) begin n_err++; $display("FAIL rand_cnt cyc %0d got %0d want %0d", c, out_cnt, mq.size()); end
      n_cmp++; if (out_vld !== (mq.size() > 0)) begin n_err++; $display("FAIL rand_vld cyc %0d got %b", c, out_vld); end
      if (mq.size() > 0) begin
        h = mq[0];
        n_cmp++; if (out_bus1 !== h[31:0] || out_pad !== h[32]) begin n_err++; $display("FAIL rand_head cyc %0d got %h/%b want %h/%b", c, out_bus1, out_pad, h[31:0], h[32]); end
`ifdef EXAMPLE_PACK_PARITY_EN
        n_cmp++; if (out_par !== ^h[31:0]) begin n_err++; $display("FAIL rand_par cyc %0d got %b", c, out_par); end
`endif
      end
      tick();
    end
    // drain so later tests start empty and in LOW
    for (int c = 0; c < 8; c++) begin drive(0, 16'h0, 1, 1); tick(); end
    drive(0, 16'h0, 0, 0);
    n_cmp++; if (out_cnt !== 3'd0) begin n_err++; $display("FAIL rand_drain got %0d want 0", out_cnt); end
    tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) begin drive(1, 16'(i + 16'h0100), 0, 0); tick(); end
    drive(0, 16'h0, 0, 0);
    n_cmp++; if (out_cnt !== 3'd3) begin n_err++; $display("FAIL rstmid_precnt got %0d want 3", out_cnt); end
    #2;
    rst_n = 0;
    #1;
    n_cmp++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL rstmid_vld got %b want 0", out_vld); end
    n_cmp++; if (out_cnt !== 3'd0) begin n_err++; $display("FAIL rstmid_cnt got %0d want 0", out_cnt); end
    n_cmp++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL rstmid_rdy got %b want 1", in_rdy); end
    model_clear();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    drive(1, 16'h1111, 0, 1); tick();
    drive(1, 16'h2222, 0, 1); tick();
    drive(0, 16'h0, 0, 1);
    n_cmp++; if (out_bus1 !== 32'h2222_1111 || out_pad !== 1'b0) begin n_err++; $display("FAIL rstmid_clean_pair got %h/%b want 22221111/0", out_bus1, out_pad); end
    tick();
  endtask

`ifdef EXAMPLE_PACK_PARITY_EN
  task automatic test_parity();
    drive(1, 16'h0007, 1, 0); tick();
    drive(1, 16'h0003, 1, 0); tick();
    drive(0, 16'h0, 0, 1);
    n_cmp++; if (out_par !== 1'b1) begin n_err++; $display("FAIL parity_7 got %b want 1", out_par); end
    tick();
    drive(0, 16'h0, 0, 1);
    n_cmp++; if (out_par !== 1'b0) begin n_err++; $display("FAIL parity_3 got %b want 0", out_par); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_pair();
    test_flush_half();
    test_flush_low();
    test_full();
    test_random();
    test_reset_mid();
`ifdef EXAMPLE_PACK_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
